// File: rtl/cgra_output_serializer.sv
// cgra_output_serializer: captures per-column FU results and shifts them out MSB-first in lock-step.
// Optional even-parity bit per column appended after the LSB when CGRA_OUT_PARITY_EN is defined.
module cgra_output_serializer #(
  parameter int NUM_COLS   = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           capture_i,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] results_i,
  input  logic                           send_i,
  output logic [NUM_COLS-1:0]            data_o,
  output logic                           valid_o,
  output logic                           done_o,
  output logic                           overrun_o
);
`ifdef CGRA_OUT_PARITY_EN
  localparam int L = DATA_WIDTH + 1;
`else
  localparam int L = DATA_WIDTH;
`endif
  localparam int CW = $clog2(L + 1);
  localparam logic [0:0] IDLE = 1'b0, SEND = 1'b1;
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic [NUM_COLS-1:0][L-1:0] sr, ld;
  logic last, load;
  genvar c;
  for (c = 0; c < NUM_COLS; c++) begin : g_col
`ifdef CGRA_OUT_PARITY_EN
    assign ld[c] = {results_i[c*DATA_WIDTH +: DATA_WIDTH], ^results_i[c*DATA_WIDTH +: DATA_WIDTH]};
`else
    assign ld[c] = results_i[c*DATA_WIDTH +: DATA_WIDTH];
`endif
    // shift registers drain to zero, so the MSB is already 0 whenever idle
    assign data_o[c] = sr[c][L-1];
  end
  always_comb begin
    last = (state == SEND) && send_i && (cnt == CW'(1));
    load = capture_i && ((state == IDLE) || last);
  end
  assign valid_o = state[0];
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      done_o <= last;
      if (capture_i && (state == SEND) && !last) overrun_o <= 1'b1;
      if (load) begin
        sr    <= ld;
        cnt   <= CW'(L);
        state <= SEND;
      end else if ((state == SEND) && send_i) begin
        for (int i = 0; i < NUM_COLS; i++) sr[i] <= sr[i] << 1;
        cnt   <= cnt - 1'b1;
        state <= last ? IDLE : SEND;
      end
    end
  end
endmodule

// File: tb/tb_cgra_output_serializer.sv
// tb_cgra_output_serializer: directed checks of framing, stall, overrun, back-to-back and reset.
module tb_cgra_output_serializer;
  logic clk = 1'b0, rst = 1'b0, cap = 1'b0, send = 1'b0;
  logic [7:0] res = '0;
  logic [1:0] data;
  logic valid, done, ovr;
  int total = 0, bad = 0;
  cgra_output_serializer #(.NUM_COLS(2), .DATA_WIDTH(4)) dut (
    .clk_i(clk), .reset_i(rst), .capture_i(cap), .results_i(res), .send_i(send),
    .data_o(data), .valid_o(valid), .done_o(done), .overrun_o(ovr)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic out(input string tag, input logic [1:0] d, input logic v, input logic dn, input logic ov);
    chk({tag, "_data"}, {2'b0, data}, {2'b0, d});
    chk({tag, "_valid"}, {3'b0, valid}, {3'b0, v});
    chk({tag, "_done"}, {3'b0, done}, {3'b0, dn});
    chk({tag, "_ovr"}, {3'b0, ovr}, {3'b0, ov});
  endtask
  // with parity, the A/7 frame carries one more bit: col1 parity 1, col0 parity 0
  task automatic par_bit(input string tag, input logic ov);
`ifdef CGRA_OUT_PARITY_EN
    tick();
    out(tag, 2'b10, 1'b1, 1'b0, ov);
`endif
  endtask
  initial begin
    rst = 1'b1; tick(); rst = 1'b0;
    out("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    res = {4'h7, 4'hA};
    cap = 1'b1; tick(); cap = 1'b0;
    out("basic_b0", 2'b01, 1'b1, 1'b0, 1'b0);
    send = 1'b1;
    tick(); out("basic_b1", 2'b10, 1'b1, 1'b0, 1'b0);
    tick(); out("basic_b2", 2'b11, 1'b1, 1'b0, 1'b0);
    tick(); out("basic_b3", 2'b10, 1'b1, 1'b0, 1'b0);
    par_bit("basic_par", 1'b0);
    tick(); out("basic_done", 2'b00, 1'b0, 1'b1, 1'b0);
    send = 1'b0;
    tick(); out("basic_after", 2'b00, 1'b0, 1'b0, 1'b0);
    cap = 1'b1; tick(); cap = 1'b0;
    send = 1'b1; tick(); tick(); send = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); out("stall_hold", 2'b11, 1'b1, 1'b0, 1'b0);
    end
    send = 1'b1;
    tick(); out("stall_b3", 2'b10, 1'b1, 1'b0, 1'b0);
    par_bit("stall_par", 1'b0);
    tick(); out("stall_done", 2'b00, 1'b0, 1'b1, 1'b0);
    send = 1'b0;
    cap = 1'b1; tick(); cap = 1'b0;
    send = 1'b1; tick(); send = 1'b0;
    res = {4'h7, 4'h0};
    cap = 1'b1; tick(); cap = 1'b0;
    out("ovr_b1", 2'b10, 1'b1, 1'b0, 1'b1);
    send = 1'b1;
    tick(); out("ovr_b2", 2'b11, 1'b1, 1'b0, 1'b1);
    tick(); out("ovr_b3", 2'b10, 1'b1, 1'b0, 1'b1);
    par_bit("ovr_par", 1'b1);
    tick(); out("ovr_done", 2'b00, 1'b0, 1'b1, 1'b1);
    send = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    out("rst_clr_ovr", 2'b00, 1'b0, 1'b0, 1'b0);
    res = {4'h7, 4'hA};
    cap = 1'b1; tick(); cap = 1'b0;
    send = 1'b1; tick(); tick(); tick();
`ifdef CGRA_OUT_PARITY_EN
    tick();
`endif
    cap = 1'b1; tick(); cap = 1'b0;
    out("b2b_done", 2'b01, 1'b1, 1'b1, 1'b0);
    tick(); out("b2b_b1", 2'b10, 1'b1, 1'b0, 1'b0);
    tick(); out("b2b_b2", 2'b11, 1'b1, 1'b0, 1'b0);
    tick(); out("b2b_b3", 2'b10, 1'b1, 1'b0, 1'b0);
    par_bit("b2b_par", 1'b0);
    tick(); out("b2b_done2", 2'b00, 1'b0, 1'b1, 1'b0);
    send = 1'b0;
    cap = 1'b1; tick(); cap = 1'b0;
    send = 1'b1; tick(); tick(); send = 1'b0;
    out("mid_b2", 2'b11, 1'b1, 1'b0, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    out("mid_rst", 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); out("mid_nodone", 2'b00, 1'b0, 1'b0, 1'b0);
    send = 1'b1; tick(); send = 1'b0;
    out("mid_idle_send", 2'b00, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
